squeeze_layer_sequencer: RTL and testbench

Controller that sequences one 1x1 squeeze-convolution layer on the shared DSP_NO-wide MAC array.
- Walks output pixels and input channels, issuing IFM RAM reads and weight-ROM addresses.
- Generates the MAC enable/clear strobes and the OFM write strobe per pixel.
- Runs a start/done/ack handshake with the top-level layer scheduler.
- Sits between the layer scheduler, the IFM/OFM RAMs and the MAC/bias/ReLU datapath.

---
 rtl/sqz_seq_pkg.sv | 27 ++
 rtl/sqz_seq_delay.sv | 32 +++
 rtl/squeeze_layer_sequencer.sv | 131 +++++++++++++
 tb/tb_squeeze_layer_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqz_seq_pkg.sv
// Shared types for the squeeze-layer sequencer: FSM states, delay-line entry
// and sizing helpers.
package sqz_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Pixel field is fixed-width so the struct can live in the package;
    // layers up to 256x256 output pixels fit.
    localparam int PIX_MAX_W = 16;

    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [PIX_MAX_W-1:0] pix;
    } dl_entry_t;

    function automatic int pix_count(input int wout);
        return wout * wout;
    endfunction

    // Index width that never collapses to zero bits (e.g. CHIN=1).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sqz_seq_delay.sv
// Stallable shift register of delay-line entries; aligns issue side-band
// information with operands arriving at the MAC array.
module sqz_seq_delay
    import sqz_seq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      stall,
    input  dl_entry_t din,
    output dl_entry_t dout
);

    dl_entry_t [DEPTH-1:0] stages;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: this is a short control pipeline, not a storage array, so every
        // stage is reset; a stale valid bit would fire a spurious MAC or OFM write.
        if (!rst) begin
            stages <= '0;
        end else if (!stall) begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/squeeze_layer_sequencer.sv
// Sequencer for one 1x1 squeeze-convolution layer on the shared MAC array.
// Optional macro SQZ_SEQ_PERF_EN adds a saturating busy-cycle counter (perf_cycles).
module squeeze_layer_sequencer
    import sqz_seq_pkg::*;
#(
    parameter int WOUT     = 8,
    parameter int CHIN     = 512,
    parameter int PIPE_LAT = 2,
    parameter int PIX_W    = idx_width(pix_count(WOUT)),
    parameter int CH_W     = idx_width(CHIN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stall,
    output logic                  ifm_rd_en,
    output logic [PIX_W+CH_W-1:0] ifm_rd_addr,
    output logic [CH_W-1:0]       wrom_addr,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic                  ofm_wr_en,
    output logic [PIX_W-1:0]      ofm_wr_addr,
    output logic                  busy,
    output logic                  done,
    input  logic                  done_ack
`ifdef SQZ_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);

    localparam int NPIX = pix_count(WOUT);
    localparam int AW   = PIX_W + CH_W;

    state_t               state, state_nxt;
    logic [PIX_W-1:0]     pix;
    logic [CH_W-1:0]      ch;
    logic                 last_ch, last_pix, start_acc, issue, last_wr;
    dl_entry_t            dl_in, dl_out;
    logic                 wr_valid;
    logic [PIX_MAX_W-1:0] wr_pix;

    assign last_ch   = (ch == CH_W'(CHIN - 1));
    assign last_pix  = (pix == PIX_W'(NPIX - 1));
    assign start_acc = (state == IDLE) && start;
    assign issue     = (state == RUN) && !stall;
    assign last_wr   = wr_valid && !stall && (wr_pix == PIX_MAX_W'(NPIX - 1));

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: all clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (issue && last_ch && last_pix) state_nxt = DRAIN;
            DRAIN:   if (last_wr) state_nxt = DONE;
            DONE:    if (done_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ifm_rd_en = issue;
        busy      = (state == RUN) || (state == DRAIN);
        done      = (state == DONE);
        mac_en    = dl_out.valid && !stall;
        mac_clr   = dl_out.valid && dl_out.first && !stall;
        ofm_wr_en = wr_valid && !stall;
    end

    // Channel is the inner loop; both counters return to zero after the final issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix <= '0;
            ch  <= '0;
        end else if (start_acc) begin
            pix <= '0;
            ch  <= '0;
        end else if (issue) begin
            if (last_ch) begin
                ch  <= '0;
                pix <= last_pix ? '0 : pix + 1'b1;
            end else begin
                ch <= ch + 1'b1;
            end
        end
    end

    assign ifm_rd_addr = AW'(pix) * AW'(CHIN) + AW'(ch);
    assign wrom_addr   = ch;

    assign dl_in = '{valid: (state == RUN), first: (ch == '0), last: last_ch,
                     pix: PIX_MAX_W'(pix)};

    sqz_seq_delay #(.DEPTH(PIPE_LAT)) u_delay (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .din   (dl_in),
        .dout  (dl_out)
    );

    // Bias/ReLU result is ready one cycle after the pixel's final product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_valid <= 1'b0;
            wr_pix   <= '0;
        end else if (!stall) begin
            wr_valid <= dl_out.valid && dl_out.last;
            wr_pix   <= dl_out.pix;
        end
    end

    assign ofm_wr_addr = wr_pix[PIX_W-1:0];

`ifdef SQZ_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          perf_cycles <= '0;
        else if (start_acc)                perf_cycles <= '0;
        else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_squeeze_layer_sequencer.sv
// Scoreboard bench for squeeze_layer_sequencer: dut_a (WOUT=2, CHIN=4) and
// dut_b (WOUT=2, CHIN=1); perf_cycles is checked when SQZ_SEQ_PERF_EN is defined.
module tb_squeeze_layer_sequencer;

    typedef struct {
        int unsigned val;
        int unsigned cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0, stall_a = 1'b0, ack_a = 1'b0;
    logic start_b = 1'b0, stall_b = 1'b0, ack_b = 1'b0;

    logic       a_rd_en, a_mac_en, a_mac_clr, a_wr_en, a_busy, a_done;
    logic [3:0] a_rd_addr;
    logic [1:0] a_wrom, a_wr_addr;
    logic       b_rd_en, b_mac_en, b_mac_clr, b_wr_en, b_busy, b_done;
    logic [2:0] b_rd_addr;
    logic [0:0] b_wrom;
    logic [1:0] b_wr_addr;
`ifdef SQZ_SEQ_PERF_EN
    logic [31:0] a_perf, b_perf;
`endif

    ev_t rd_a[$], mac_a[$], wr_a[$], dn_a[$];
    ev_t rd_b[$], mac_b[$], wr_b[$], dn_b[$];

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;
    bit          mon_on = 1'b0;
    logic        a_done_q = 1'b0, b_done_q = 1'b0;

    squeeze_layer_sequencer #(.WOUT(2), .CHIN(4), .PIPE_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stall(stall_a),
        .ifm_rd_en(a_rd_en), .ifm_rd_addr(a_rd_addr), .wrom_addr(a_wrom),
        .mac_en(a_mac_en), .mac_clr(a_mac_clr), .ofm_wr_en(a_wr_en),
        .ofm_wr_addr(a_wr_addr), .busy(a_busy), .done(a_done), .done_ack(ack_a)
`ifdef SQZ_SEQ_PERF_EN
        , .perf_cycles(a_perf)
`endif
    );

    squeeze_layer_sequencer #(.WOUT(2), .CHIN(1), .PIPE_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stall(stall_b),
        .ifm_rd_en(b_rd_en), .ifm_rd_addr(b_rd_addr), .wrom_addr(b_wrom),
        .mac_en(b_mac_en), .mac_clr(b_mac_clr), .ofm_wr_en(b_wr_en),
        .ofm_wr_addr(b_wr_addr), .busy(b_busy), .done(b_done), .done_ack(ack_b)
`ifdef SQZ_SEQ_PERF_EN
        , .perf_cycles(b_perf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic compare_ev(input string name, input int have, input ev_t e, input int unsigned got);
        if (have == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: unexpected strobe value %0d at cycle %0d", name, got, cyc);
        end else begin
            check({name, " value"}, got, e.val);
            check({name, " cycle"}, cyc, e.cyc);
        end
    endtask

    function automatic int unsigned shift_cyc(input int unsigned t, input int unsigned from,
                                              input int unsigned len);
        return (len != 0 && t >= from) ? t + len : t;
    endfunction

    // Expected events of one layer started so that issue 0 appears in cycle s.
    // Events whose unstalled cycle is at or past lim are not expected (abort).
    task automatic push_exp(input bit which, input int unsigned s, input int chin, input int npix,
                            input int unsigned stall_at, input int unsigned stall_len,
                            input int unsigned lim);
        ev_t         e;
        int unsigned t;
        for (int i = 0; i < chin * npix; i++) begin
            t = s + i;
            if (t < lim) begin
                e.val = i;
                e.cyc = shift_cyc(t, s + stall_at, stall_len);
                if (which) rd_b.push_back(e); else rd_a.push_back(e);
            end
            t = s + i + 2;
            if (t < lim) begin
                e.val = ((i % chin) == 0) ? 1 : 0;
                e.cyc = shift_cyc(t, s + stall_at, stall_len);
                if (which) mac_b.push_back(e); else mac_a.push_back(e);
            end
        end
        for (int k = 0; k < npix; k++) begin
            t = s + chin * k + chin + 2;
            if (t < lim) begin
                e.val = k;
                e.cyc = shift_cyc(t, s + stall_at, stall_len);
                if (which) wr_b.push_back(e); else wr_a.push_back(e);
            end
        end
        t = s + chin * npix + 3;
        if (t < lim) begin
            e.val = 1;
            e.cyc = shift_cyc(t, s + stall_at, stall_len);
            if (which) dn_b.push_back(e); else dn_a.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a strobe.
    always @(negedge clk) begin
        ev_t e;
        int  have;
        if (mon_on) begin
            if (a_rd_en)  begin have = rd_a.size();  if (have > 0) e = rd_a.pop_front();  compare_ev("a_rd", have, e, a_rd_addr); end
            if (a_mac_en) begin have = mac_a.size(); if (have > 0) e = mac_a.pop_front(); compare_ev("a_mac_clr", have, e, a_mac_clr); end
            if (a_wr_en)  begin have = wr_a.size();  if (have > 0) e = wr_a.pop_front();  compare_ev("a_wr", have, e, a_wr_addr); end
            if (a_done && !a_done_q) begin have = dn_a.size(); if (have > 0) e = dn_a.pop_front(); compare_ev("a_done", have, e, 1); end
            if (b_rd_en)  begin have = rd_b.size();  if (have > 0) e = rd_b.pop_front();  compare_ev("b_rd", have, e, b_rd_addr); end
            if (b_mac_en) begin have = mac_b.size(); if (have > 0) e = mac_b.pop_front(); compare_ev("b_mac_clr", have, e, b_mac_clr); end
            if (b_wr_en)  begin have = wr_b.size();  if (have > 0) e = wr_b.pop_front();  compare_ev("b_wr", have, e, b_wr_addr); end
            if (b_done && !b_done_q) begin have = dn_b.size(); if (have > 0) e = dn_b.pop_front(); compare_ev("b_done", have, e, 1); end
            if (a_mac_clr && !a_mac_en) check("a_clr_without_en", 1, 0);
            a_done_q = a_done;
            b_done_q = b_done;
        end
    end

    task automatic start_layer(input bit which, output int unsigned s);
        @(posedge clk); #1;
        if (which) start_b = 1'b1; else start_a = 1'b1;
        s = cyc + 1;
    endtask

    task automatic release_start(input bit which);
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check(which ? "b_busy_after_start" : "a_busy_after_start", which ? b_busy : a_busy, 1);
    endtask

    task automatic wait_done(input bit which, input int budget);
        int n = 0;
        while (!(which ? b_done : a_done) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(which ? "b_done_reached" : "a_done_reached", which ? b_done : a_done, 1);
        check(which ? "b_busy_in_done" : "a_busy_in_done", which ? b_busy : a_busy, 0);
    endtask

    task automatic ack_done(input bit which);
        if (which) ack_b = 1'b1; else ack_a = 1'b1;
        @(posedge clk); #1;
        ack_a = 1'b0;
        ack_b = 1'b0;
        check(which ? "b_done_after_ack" : "a_done_after_ack", which ? b_done : a_done, 0);
        check(which ? "b_busy_after_ack" : "a_busy_after_ack", which ? b_busy : a_busy, 0);
    endtask

    task automatic run_plain_a(input int exp_perf);
        int unsigned s;
        start_layer(0, s);
        push_exp(0, s, 4, 4, 0, 0, 32'hFFFF_FFFF);
        release_start(0);
        wait_done(0, 60);
`ifdef SQZ_SEQ_PERF_EN
        check("a_perf_cycles", a_perf, exp_perf);
`else
        if (exp_perf < 0) $display("[TB] note: negative perf expectation");
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned s;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_rd_en", a_rd_en, 0);
        check("rst_a_rd_addr", a_rd_addr, 0);
        check("rst_a_wrom", a_wrom, 0);
        check("rst_a_mac_en", a_mac_en, 0);
        check("rst_a_mac_clr", a_mac_clr, 0);
        check("rst_a_wr_en", a_wr_en, 0);
        check("rst_a_wr_addr", a_wr_addr, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_b_busy", b_busy, 0);
        check("rst_b_done", b_done, 0);
        rst = 1'b1;
        mon_on = 1'b1;

        // Plain layer: 16 issues + 3 drain cycles busy
        run_plain_a(19);

        // done held without ack; start in DONE is ignored
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start_a = (i == 1 || i == 2);
            check("a_done_held", a_done, 1);
            check("a_busy_held_low", a_busy, 0);
        end
        start_a = 1'b0;
        ack_done(0);
        repeat (3) begin
            @(posedge clk); #1;
            check("a_idle_no_read", a_rd_en, 0);
            check("a_idle_done_low", a_done, 0);
        end

        // Stall for 3 cycles at issue index 6
        start_layer(0, s);
        push_exp(0, s, 4, 4, 6, 3, 32'hFFFF_FFFF);
        release_start(0);
        while (cyc != s + 6) begin
            @(posedge clk); #1;
        end
        stall_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_rd_en", a_rd_en, 0);
            check("stall_mac_en", a_mac_en, 0);
            check("stall_wr_en", a_wr_en, 0);
            check("stall_busy", a_busy, 1);
            @(posedge clk); #1;
        end
        stall_a = 1'b0;
        wait_done(0, 60);
`ifdef SQZ_SEQ_PERF_EN
        check("a_perf_cycles_stall", a_perf, 22);
`endif
        ack_done(0);

        // Abort by reset at issue index 9
        start_layer(0, s);
        push_exp(0, s, 4, 4, 0, 0, s + 9);
        release_start(0);
        while (cyc != s + 9) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        check("abort_rd_en", a_rd_en, 0);
        check("abort_rd_addr", a_rd_addr, 0);
        check("abort_mac_en", a_mac_en, 0);
        check("abort_wr_en", a_wr_en, 0);
        check("abort_busy", a_busy, 0);
        check("abort_done", a_done, 0);
        check("abort_rd_left", rd_a.size(), 0);
        check("abort_mac_left", mac_a.size(), 0);
        check("abort_wr_left", wr_a.size(), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        run_plain_a(19);
        ack_done(0);

        // CHIN=1: every mac_en carries mac_clr, writes back-to-back
        start_layer(1, s);
        push_exp(1, s, 1, 4, 0, 0, 32'hFFFF_FFFF);
        release_start(1);
        wait_done(1, 40);
`ifdef SQZ_SEQ_PERF_EN
        check("b_perf_cycles", b_perf, 7);
`endif
        ack_done(1);

        repeat (4) @(posedge clk);
        #1;
        check("end_rd_a_empty", rd_a.size(), 0);
        check("end_mac_a_empty", mac_a.size(), 0);
        check("end_wr_a_empty", wr_a.size(), 0);
        check("end_dn_a_empty", dn_a.size(), 0);
        check("end_rd_b_empty", rd_b.size(), 0);
        check("end_mac_b_empty", mac_b.size(), 0);
        check("end_wr_b_empty", wr_b.size(), 0);
        check("end_dn_b_empty", dn_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
